// File: rtl/forward_hazard_unit.sv
// ID-stage operand forwarding and hazard detection. Selects are registered into EX. Also contains
// a run/stall/freeze FSM and a saturating stall-cycle counter.
module forward_hazard_unit #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic                      mem_busy,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_read,
  input  logic [ADDR_W-1:0]         ex_dest,
  input  logic                      mem_wb_en,
  input  logic [ADDR_W-1:0]         mem_dest,
  output logic [NUM_SRC*2-1:0]      sel_src,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FROZEN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SRC-1:0]     match_ex, match_mem;
  logic                   haz_ld, haz_nf, hazard;
  logic [NUM_SRC*2-1:0]   next_sel, sel_d, sel_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  // Source matching against EX and MEM destinations; EX wins when both match.
  always_comb begin
    match_ex  = '0;
    match_mem = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      match_ex[i]  = id_valid & id_src_used[i] & ex_wb_en &
                     (id_src[i*ADDR_W +: ADDR_W] == ex_dest);
      match_mem[i] = id_valid & id_src_used[i] & mem_wb_en &
                     (id_src[i*ADDR_W +: ADDR_W] == mem_dest);
    end

    haz_ld = (|match_ex) & ex_mem_read;
    haz_nf = ~fwd_en & (|(match_ex | match_mem));
    hazard = haz_ld | haz_nf;

    next_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (fwd_en && !hazard) begin
        if (match_ex[i]) begin
          next_sel[i*2 +: 2] = 2'b01;
        end else if (match_mem[i]) begin
          next_sel[i*2 +: 2] = 2'b10;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN, STALL: begin
        if (mem_busy)    state_d = FROZEN;
        else if (hazard) state_d = STALL;
        else             state_d = RUN;
      end
      FROZEN: begin
        if (!mem_busy) state_d = hazard ? STALL : RUN;
      end
      default: state_d = RUN;
    endcase

    stall  = mem_busy | hazard;
    bubble = hazard & ~mem_busy;

    // EX is frozen while memory is busy, so its selects must hold.
    if (mem_busy)    sel_d = sel_q;
    else if (hazard) sel_d = '0;
    else             sel_d = next_sel;

    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_src   = sel_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model, a monitor compares.
module tb_forward_hazard_unit;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst, fwd_en, mem_busy, id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      ex_wb_en, ex_mem_read, mem_wb_en;
  logic [ADDR_W-1:0]         ex_dest, mem_dest;
  logic [NUM_SRC*2-1:0]      sel_src;
  logic                      stall, bubble;
  logic [CNT_W-1:0]          stall_cnt;

  forward_hazard_unit #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .mem_busy(mem_busy), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_wb_en(mem_wb_en),
    .mem_dest(mem_dest), .sel_src(sel_src), .stall(stall), .bubble(bubble),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 stall;
    logic                 bubble;
    logic [NUM_SRC*2-1:0] sel;
    logic [CNT_W-1:0]     cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: per-source select code (0 regfile, 1 MEM, 2 WB) and stall count.
  int   m_sel[NUM_SRC];
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want,
                     input logic act_x);
    n_cmp++;
    if (act_x || act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",  32'(stall),     32'(e.stall),  $isunknown(stall));
        chk("bubble", 32'(bubble),    32'(e.bubble), $isunknown(bubble));
        chk("sel",    32'(sel_src),   32'(e.sel),    $isunknown(sel_src));
        chk("cnt",    32'(stall_cnt), 32'(e.cnt),    $isunknown(stall_cnt));
      end
    end
  end

  // Apply the currently driven inputs for one cycle.
  task automatic issue();
    bit   me[NUM_SRC], mm[NUM_SRC];
    bit   any_ex, any_m, haz, st;
    int   s;
    exp_t e;
    any_ex = 0; any_m = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = int'(id_src[i*ADDR_W +: ADDR_W]);
      me[i] = id_valid && id_src_used[i] && ex_wb_en  && (s == int'(ex_dest));
      mm[i] = id_valid && id_src_used[i] && mem_wb_en && (s == int'(mem_dest));
      any_ex |= me[i];
      any_m  |= me[i] | mm[i];
    end
    haz = (any_ex && ex_mem_read) || (!fwd_en && any_m);
    st  = mem_busy || haz;
    e.stall  = st;
    e.bubble = haz && !mem_busy;
    e.sel    = '0;
    for (int i = 0; i < NUM_SRC; i++) e.sel[i*2 +: 2] = 2'(m_sel[i]);
    e.cnt    = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      m_cnt = 0;
      for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    end else begin
      if (st && m_cnt < CNT_MAX) m_cnt++;
      if (!mem_busy)
        for (int i = 0; i < NUM_SRC; i++)
          m_sel[i] = (haz || !fwd_en) ? 0 : me[i] ? 1 : mm[i] ? 2 : 0;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1; fwd_en = 1; mem_busy = 0; id_valid = 1; id_src = '0; id_src_used = '0;
    ex_wb_en = 0; ex_mem_read = 0; ex_dest = '0; mem_wb_en = 0; mem_dest = '0;
  endtask

  task automatic set_src(input int i, input int r);
    id_src[i*ADDR_W +: ADDR_W] = ADDR_W'(r);
    id_src_used[i] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    idle();
    rst = 0;
    for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    m_cnt = 0;
    @(posedge clk); #1;

    // Reset held with a load-use hazard present: stall asserts but registers stay clear.
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 4'd2; set_src(0, 2);
    issue(); issue();
    idle(); issue();

    // ALU-ALU forward from EX.
    ex_wb_en = 1; ex_dest = 4'd3; set_src(0, 3);
    issue(); idle(); issue();

    // EX and MEM both match; src2 only in MEM.
    ex_wb_en = 1; ex_dest = 4'd5; mem_wb_en = 1; mem_dest = 4'd5;
    set_src(0, 5); set_src(1, 5); mem_dest = 4'd5;
    issue();
    idle(); ex_wb_en = 1; ex_dest = 4'd5; mem_wb_en = 1; mem_dest = 4'd7;
    set_src(0, 5); set_src(1, 5); set_src(2, 7);
    issue(); idle(); issue();

    // Load-use: one bubble, then the load is in MEM and forwards from WB.
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 4'd2; set_src(1, 2);
    issue();
    idle(); mem_wb_en = 1; mem_dest = 4'd2; set_src(1, 2);
    issue(); idle(); issue();

    // Stall-only mode: EX then MEM match both stall.
    fwd_en = 0; ex_wb_en = 1; ex_dest = 4'd4; set_src(2, 4);
    issue();
    idle(); fwd_en = 0; mem_wb_en = 1; mem_dest = 4'd4; set_src(2, 4);
    issue(); idle(); issue();

    // Establish a select, then freeze long enough to saturate the counter.
    ex_wb_en = 1; ex_dest = 4'd9; set_src(0, 9);
    issue();
    mem_busy = 1;
    for (int k = 0; k < 18; k++) issue();
    idle(); issue();

    // Reset mid-freeze.
    mem_busy = 1; issue(); rst = 0; issue(); idle(); issue();

    // Randomised traffic over a small register range to force frequent matches.
    for (int k = 0; k < 2000; k++) begin
      rst         = ($urandom_range(0, 60) != 0);
      fwd_en      = ($urandom_range(0, 3) != 0);
      mem_busy    = ($urandom_range(0, 7) == 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_src_used = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) id_src[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
      ex_wb_en    = $urandom_range(0, 1);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_dest     = ADDR_W'($urandom_range(0, 3));
      mem_wb_en   = $urandom_range(0, 1);
      mem_dest    = ADDR_W'($urandom_range(0, 3));
      issue();
    end

    idle();
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk); #1;
      budget++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
